rle1_arb: RTL and testbench
===========================

RLE1_ARB -- requirements
Module: rle1_arb

Interface
REQ-001 SHALL have parameter PRIO_INIT, default 0, giving the requester index that holds round-robin priority after reset.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports in0_r/in1_r  input  2  requester symbol stream, {symbol, last}.
REQ-005 SHALL have ports in0_r_vld/in1_r_vld  input  1  and in0_r_rdy/in1_r_rdy  output  1  as the requester handshakes.
REQ-006 SHALL have port enc_in  output  2, enc_in_vld  output  1, and enc_in_rdy  input  1; these drive the shared rle1 encoder input channel.
REQ-007 SHALL have port enc_out  input  6  {symbol, count[3:0], last}, enc_out_vld  input  1, and enc_out_rdy  output  1; these carry the encoder output channel.
REQ-008 SHALL have ports out0_s/out1_s  output  6, out0_s_vld/out1_s_vld  output  1, and out0_s_rdy/out1_s_rdy  input  1; these are the per-requester run outputs.
REQ-009 SHALL have port busy  output  1 (frame in flight), port owner  output  1 (current grant index), and ports frames0/frames1  output  8 (completed-frame counters).

Function
REQ-010 SHALL implement FSM states IDLE, GRANT and DRAIN, plus registers owner, prio, frames0 and frames1.
REQ-011 In IDLE, if exactly one inN_r_vld is 1, the FSM SHALL grant that requester; if both are 1, it SHALL grant index prio.
REQ-012 On a grant, owner SHALL load the granted index, prio SHALL load the other index, and the FSM SHALL enter GRANT on the next cycle (1-cycle grant latency).
REQ-013 In IDLE, all inN_r_rdy, enc_in_vld, enc_out_rdy and outN_s_vld SHALL be 0.
REQ-014 In GRANT: enc_in SHALL equal in{owner}_r, enc_in_vld SHALL equal in{owner}_r_vld, in{owner}_r_rdy SHALL equal enc_in_rdy, and the non-owner rdy SHALL be 0; all are combinational with no added latency.
REQ-015 In GRANT and DRAIN: out{owner}_s SHALL equal enc_out, out{owner}_s_vld SHALL equal enc_out_vld, enc_out_rdy SHALL equal out{owner}_s_rdy, and the non-owner vld SHALL be 0; the non-owner data SHALL hold 0.
REQ-016 GRANT→DRAIN SHALL occur on an input transfer (enc_in_vld & enc_in_rdy) with last bit = 1.
REQ-017 DRAIN→IDLE SHALL occur on an output transfer (enc_out_vld & enc_out_rdy) with enc_out bit0 (last) = 1; frames{owner} SHALL increment in that same cycle, wrapping 255→0.
REQ-018 An output transfer with last = 1 while in GRANT SHALL be routed normally and SHALL NOT change state or counters.
REQ-019 A requester asserting vld while the other owns the encoder SHALL wait with rdy = 0, and its data SHALL be ignored.
REQ-020 busy SHALL be 1 in GRANT and DRAIN and 0 in IDLE; owner SHALL hold its value in IDLE.
REQ-021 No new grant SHALL be issued in the DRAIN→IDLE cycle; arbitration SHALL resume in IDLE on the following cycle.

Reset
REQ-022 Asserting reset SHALL immediately force state = IDLE, owner = 0, prio = PRIO_INIT, frames0 = frames1 = 0, busy = 0, and every vld/rdy output = 0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame without incrementing any counter; the encoder SHALL share the same reset net.

Structure
REQ-024 Package rle1_pkg SHALL hold the FSM state enum, the input field indices (SYM = 1, LAST = 0), the output field indices (SYM = 5, COUNT = 4:1, LAST = 0), and the counter width of 8.
REQ-025 Sub-module rle1_rr_pick (combinational, 2-way round-robin: vld[1:0], prio → gnt_vld, gnt_idx) SHALL be the only sub-module; the encoder SHALL be instantiated outside rle1_arb.

Verification
REQ-026 Single frame: in0 sends {1,0},{1,0},{0,1} while the encoder is attached → out0 receives {1,2,0} then {0,1,1}; frames0 = 1; out1_s_vld is never 1.
REQ-027 Contention: in0_vld and in1_vld both rise in the same IDLE cycle with PRIO_INIT = 0 → in0 granted first; the in1 frame starts only after in0's last output; a second simultaneous request grants in1 first.
REQ-028 Backpressure: out0_s_rdy held 0 for 5 cycles during DRAIN → enc_out_rdy = 0 for those cycles, the FSM stays in DRAIN, and no request is granted.
REQ-029 Wrap: 256 single-symbol frames on in1 → frames1 returns to 0 and frames0 stays 0.
REQ-030 Reset mid-GRANT after 2 symbols → all outputs zero immediately; after release, IDLE arbitrates fresh with prio = PRIO_INIT and frames unchanged from 0.

Source files
------------

// File: rtl/rle1_pkg.sv
// Shared types and field layout for the rle1 arbiter and its encoder channels.
// Input words are {symbol, last}; encoder output words are {symbol, count[3:0], last}.
package rle1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    localparam int IN_W   = 2;
    localparam int IN_SYM  = 1;
    localparam int IN_LAST = 0;

    localparam int OUT_W      = 6;
    localparam int OUT_SYM    = 5;
    localparam int OUT_CNT_HI = 4;
    localparam int OUT_CNT_LO = 1;
    localparam int OUT_LAST   = 0;

    localparam int FRAME_CNT_W = 8;

endpackage

// File: rtl/rle1_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to prio.
module rle1_rr_pick (
    input  logic [1:0] vld,
    input  logic       prio,
    output logic       gnt_vld,
    output logic       gnt_idx
);

    always_comb begin
        gnt_vld = |vld;
        gnt_idx = 1'b0;
        case (vld)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = prio;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/rle1_arb.sv
// Frame-level arbiter sharing one external rle1 encoder between two requesters.
// state | meaning: IDLE = no frame, arbitrating | GRANT = owner streams symbols in | DRAIN = waiting for owner's last run
module rle1_arb
    import rle1_pkg::*;
#(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic [IN_W-1:0]        in0_r,
    input  logic                   in0_r_vld,
    output logic                   in0_r_rdy,
    input  logic [IN_W-1:0]        in1_r,
    input  logic                   in1_r_vld,
    output logic                   in1_r_rdy,

    output logic [IN_W-1:0]        enc_in,
    output logic                   enc_in_vld,
    input  logic                   enc_in_rdy,

    input  logic [OUT_W-1:0]       enc_out,
    input  logic                   enc_out_vld,
    output logic                   enc_out_rdy,

    output logic [OUT_W-1:0]       out0_s,
    output logic                   out0_s_vld,
    input  logic                   out0_s_rdy,
    output logic [OUT_W-1:0]       out1_s,
    output logic                   out1_s_vld,
    input  logic                   out1_s_rdy,

    output logic                   busy,
    output logic                   owner,
    output logic [FRAME_CNT_W-1:0] frames0,
    output logic [FRAME_CNT_W-1:0] frames1
);

    localparam logic PRIO_RST = 1'(PRIO_INIT);

    arb_state_e             state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   prio_q, prio_d;
    logic                   busy_q, busy_d;
    logic [FRAME_CNT_W-1:0] frames0_q, frames0_d;
    logic [FRAME_CNT_W-1:0] frames1_q, frames1_d;

    logic gnt_vld;
    logic gnt_idx;
    logic in_xfer_last;
    logic out_xfer_last;

    rle1_rr_pick u_pick (
        .vld     ({in1_r_vld, in0_r_vld}),
        .prio    (prio_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Input side is connected only while the owner is still sending its frame.
    always_comb begin
        enc_in     = '0;
        enc_in_vld = 1'b0;
        in0_r_rdy  = 1'b0;
        in1_r_rdy  = 1'b0;
        if (state_q == GRANT) begin
            enc_in     = owner_q ? in1_r : in0_r;
            enc_in_vld = owner_q ? in1_r_vld : in0_r_vld;
            in0_r_rdy  = ~owner_q & enc_in_rdy;
            in1_r_rdy  = owner_q & enc_in_rdy;
        end
    end

    always_comb begin
        out0_s      = '0;
        out0_s_vld  = 1'b0;
        out1_s      = '0;
        out1_s_vld  = 1'b0;
        enc_out_rdy = 1'b0;
        if (state_q != IDLE) begin
            if (owner_q) begin
                out1_s      = enc_out;
                out1_s_vld  = enc_out_vld;
                enc_out_rdy = out1_s_rdy;
            end else begin
                out0_s      = enc_out;
                out0_s_vld  = enc_out_vld;
                enc_out_rdy = out0_s_rdy;
            end
        end
    end

    assign in_xfer_last  = enc_in_vld & enc_in_rdy & enc_in[IN_LAST];
    assign out_xfer_last = enc_out_vld & enc_out_rdy & enc_out[OUT_LAST];

    // A last run seen during GRANT is just routed; only DRAIN closes the frame.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prio_d    = prio_q;
        frames0_d = frames0_q;
        frames1_d = frames1_q;
        case (state_q)
            IDLE: begin
                if (gnt_vld) begin
                    owner_d = gnt_idx;
                    prio_d  = ~gnt_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (in_xfer_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_xfer_last) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        frames1_d = frames1_q + FRAME_CNT_W'(1);
                    end else begin
                        frames0_d = frames0_q + FRAME_CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            prio_q    <= PRIO_RST;
            busy_q    <= 1'b0;
            frames0_q <= '0;
            frames1_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prio_q    <= prio_d;
            busy_q    <= busy_d;
            frames0_q <= frames0_d;
            frames1_q <= frames1_d;
        end
    end

    assign busy    = busy_q;
    assign owner   = owner_q;
    assign frames0 = frames0_q;
    assign frames1 = frames1_q;

endmodule

// File: tb/tb_rle1_arb.sv
// Bench for rle1_arb: behavioural encoder, queue-based requesters/sinks and a frame-level reference.
// Inputs change 1ns after the rising edge; everything is observed on the falling edge.
module tb_rle1_arb;
    import rle1_pkg::*;

    localparam int PRIO_INIT = 0;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in0_r, in1_r;
    logic       in0_r_vld, in1_r_vld, in0_r_rdy, in1_r_rdy;
    logic [1:0] enc_in;
    logic       enc_in_vld, enc_in_rdy;
    logic [5:0] enc_out;
    logic       enc_out_vld, enc_out_rdy;
    logic [5:0] out0_s, out1_s;
    logic       out0_s_vld, out1_s_vld, out0_s_rdy, out1_s_rdy;
    logic       busy, owner;
    logic [7:0] frames0, frames1;

    always #5 clk = ~clk;

    rle1_arb #(.PRIO_INIT(PRIO_INIT)) dut (
        .clk(clk), .reset(reset),
        .in0_r(in0_r), .in0_r_vld(in0_r_vld), .in0_r_rdy(in0_r_rdy),
        .in1_r(in1_r), .in1_r_vld(in1_r_vld), .in1_r_rdy(in1_r_rdy),
        .enc_in(enc_in), .enc_in_vld(enc_in_vld), .enc_in_rdy(enc_in_rdy),
        .enc_out(enc_out), .enc_out_vld(enc_out_vld), .enc_out_rdy(enc_out_rdy),
        .out0_s(out0_s), .out0_s_vld(out0_s_vld), .out0_s_rdy(out0_s_rdy),
        .out1_s(out1_s), .out1_s_vld(out1_s_vld), .out1_s_rdy(out1_s_rdy),
        .busy(busy), .owner(owner), .frames0(frames0), .frames1(frames1)
    );

    int         n_err = 0;
    int         n_chk = 0;
    logic [1:0] inq0[$], inq1[$];
    logic [5:0] expq0[$], expq1[$], encq[$];
    logic       run_have, run_sym;
    logic [3:0] run_cnt;
    int         phase;
    logic       exp_own, exp_prio;
    logic [7:0] expf0, expf1;
    logic       rnd_en, hold0;
    logic       x_in0, x_in1, x_enc_in, x_enc_out;
    logic [1:0] enc_in_s;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Queue a frame (bit k of syms = k-th symbol) and derive its expected runs.
    task automatic send(input int r, input int n, input logic [15:0] syms);
        logic [1:0] word;
        logic [5:0] w;
        logic       s;
        int         i, j;
        for (int k = 0; k < n; k++) begin
            word          = '0;
            word[IN_SYM]  = syms[k];
            word[IN_LAST] = (k == n - 1);
            if (r == 0) inq0.push_back(word);
            else        inq1.push_back(word);
        end
        i = 0;
        while (i < n) begin
            s = syms[i];
            j = i;
            while (j < n && syms[j] == s && (j - i) < 15) j++;
            w                          = '0;
            w[OUT_SYM]                 = s;
            w[OUT_CNT_HI:OUT_CNT_LO]   = 4'(j - i);
            w[OUT_LAST]                = (j == n);
            if (r == 0) expq0.push_back(w);
            else        expq1.push_back(w);
            i = j;
        end
    endtask

    task automatic enc_accept(input logic [1:0] d);
        logic s;
        s = d[IN_SYM];
        if (run_have && s == run_sym && run_cnt != 4'd15) begin
            run_cnt = run_cnt + 4'd1;
        end else begin
            if (run_have) encq.push_back({run_sym, run_cnt, 1'b0});
            run_sym  = s;
            run_cnt  = 4'd1;
            run_have = 1'b1;
        end
        if (d[IN_LAST]) begin
            encq.push_back({run_sym, run_cnt, 1'b1});
            run_have = 1'b0;
        end
    endtask

    task automatic drive();
        in0_r       = (inq0.size() != 0) ? inq0[0] : 2'b00;
        in0_r_vld   = (inq0.size() != 0) && (!rnd_en || $urandom_range(3) != 0);
        in1_r       = (inq1.size() != 0) ? inq1[0] : 2'b00;
        in1_r_vld   = (inq1.size() != 0) && (!rnd_en || $urandom_range(3) != 0);
        enc_in_rdy  = (encq.size() < 2) && (!rnd_en || $urandom_range(3) != 0);
        enc_out     = (encq.size() != 0) ? encq[0] : 6'd0;
        enc_out_vld = (encq.size() != 0);
        out0_s_rdy  = !hold0 && (!rnd_en || $urandom_range(2) != 0);
        out1_s_rdy  = (!rnd_en || $urandom_range(2) != 0);
    endtask

    task automatic monitor();
        logic [1:0] v;
        logic       g;
        logic [5:0] e;
        chk("busy", 64'(busy), 64'(phase != 0));
        chk("owner", 64'(owner), 64'(exp_own));
        chk("frames0", 64'(frames0), 64'(expf0));
        chk("frames1", 64'(frames1), 64'(expf1));
        if (phase == 0) begin
            chk("idle_outs", 64'({in0_r_rdy, in1_r_rdy, enc_in_vld, enc_out_rdy,
                                  out0_s_vld, out1_s_vld, out0_s, out1_s}), 64'(0));
        end else begin
            if (phase == 1) begin
                if (exp_own)
                    chk("route_in1", 64'({enc_in, enc_in_vld, in1_r_rdy, in0_r_rdy}),
                        64'({in1_r, in1_r_vld, enc_in_rdy, 1'b0}));
                else
                    chk("route_in0", 64'({enc_in, enc_in_vld, in0_r_rdy, in1_r_rdy}),
                        64'({in0_r, in0_r_vld, enc_in_rdy, 1'b0}));
            end else begin
                chk("drain_in", 64'({enc_in_vld, in0_r_rdy, in1_r_rdy}), 64'(0));
            end
            if (exp_own)
                chk("route_out1", 64'({out1_s, out1_s_vld, enc_out_rdy, out0_s, out0_s_vld}),
                    64'({enc_out, enc_out_vld, out1_s_rdy, 6'd0, 1'b0}));
            else
                chk("route_out0", 64'({out0_s, out0_s_vld, enc_out_rdy, out1_s, out1_s_vld}),
                    64'({enc_out, enc_out_vld, out0_s_rdy, 6'd0, 1'b0}));
        end

        x_in0     = in0_r_vld & in0_r_rdy;
        x_in1     = in1_r_vld & in1_r_rdy;
        x_enc_in  = enc_in_vld & enc_in_rdy;
        enc_in_s  = enc_in;
        x_enc_out = enc_out_vld & enc_out_rdy;

        if (out0_s_vld && out0_s_rdy) begin
            chk("out0_avail", 64'(expq0.size() != 0), 64'(1));
            if (expq0.size() != 0) begin
                e = expq0.pop_front();
                chk("out0_word", 64'(out0_s), 64'(e));
                if (e[OUT_LAST] && phase == 2) expf0 = expf0 + 8'd1;
            end
        end
        if (out1_s_vld && out1_s_rdy) begin
            chk("out1_avail", 64'(expq1.size() != 0), 64'(1));
            if (expq1.size() != 0) begin
                e = expq1.pop_front();
                chk("out1_word", 64'(out1_s), 64'(e));
                if (e[OUT_LAST] && phase == 2) expf1 = expf1 + 8'd1;
            end
        end

        v = {in1_r_vld, in0_r_vld};
        case (phase)
            0: if (v != 2'b00) begin
                g        = (v == 2'b11) ? exp_prio : v[1];
                exp_own  = g;
                exp_prio = ~g;
                phase    = 1;
            end
            1: if (x_enc_in && enc_in_s[IN_LAST]) phase = 2;
            2: if (x_enc_out && enc_out[OUT_LAST]) phase = 0;
            default: phase = 0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (x_in0) void'(inq0.pop_front());
        if (x_in1) void'(inq1.pop_front());
        if (x_enc_out) void'(encq.pop_front());
        if (x_enc_in) enc_accept(enc_in_s);
        drive();
        @(negedge clk);
        monitor();
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(inq0.size() == 0 && inq1.size() == 0 && encq.size() == 0 &&
                               expq0.size() == 0 && expq1.size() == 0 && phase == 0)) begin
            tick();
            k++;
        end
        chk(tag, 64'(k < budget), 64'(1));
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("reset_outs", 64'({busy, owner, in0_r_rdy, in1_r_rdy, enc_in_vld, enc_out_rdy,
                               out0_s_vld, out1_s_vld, frames0, frames1}), 64'(0));
        inq0.delete(); inq1.delete(); expq0.delete(); expq1.delete(); encq.delete();
        run_have = 1'b0; run_sym = 1'b0; run_cnt = 4'd0;
        phase = 0; exp_own = 1'b0; exp_prio = 1'(PRIO_INIT);
        expf0 = 8'd0; expf1 = 8'd0;
        x_in0 = 1'b0; x_in1 = 1'b0; x_enc_in = 1'b0; x_enc_out = 1'b0; enc_in_s = 2'b00;
        rnd_en = 1'b0; hold0 = 1'b0;
        drive();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int k;
        reset = 1'b0;
        rnd_en = 1'b0; hold0 = 1'b0;
        in0_r = 2'b00; in0_r_vld = 1'b0; in1_r = 2'b00; in1_r_vld = 1'b0;
        enc_in_rdy = 1'b0; enc_out = 6'd0; enc_out_vld = 1'b0;
        out0_s_rdy = 1'b0; out1_s_rdy = 1'b0;
        do_reset();

        // Contention straight out of reset: in0 first, in1 after in0 completes.
        send(0, 3, 16'b101);
        send(1, 2, 16'b11);
        tick(); tick();
        chk("cont_first_owner", 64'(owner), 64'(0));
        wait_quiet("cont_done", 200);
        chk("cont_frames", 64'({frames0, frames1}), 64'({8'd1, 8'd1}));

        // Single frame 1,1,0 on in0 -> runs {1,2,0} then {0,1,1}.
        send(0, 3, 16'b011);
        wait_quiet("single_done", 200);
        chk("single_frames0", 64'(frames0), 64'(2));

        // Second simultaneous request after in0 was last served: in1 wins.
        send(0, 2, 16'b10);
        send(1, 4, 16'b0110);
        tick(); tick();
        chk("cont_second_owner", 64'(owner), 64'(1));
        wait_quiet("cont2_done", 200);

        // Backpressure during DRAIN with in1 waiting.
        hold0 = 1'b1;
        send(0, 3, 16'b111);
        k = 0;
        while (phase != 1 && k < 20) begin tick(); k++; end
        chk("bp_grant0", 64'({phase == 1, exp_own}), 64'({1'b1, 1'b0}));
        send(1, 2, 16'b01);
        k = 0;
        while (phase != 2 && k < 50) begin tick(); k++; end
        chk("bp_reach_drain", 64'(phase == 2), 64'(1));
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_enc_out_rdy", 64'(enc_out_rdy), 64'(0));
            chk("bp_hold", 64'({busy, owner, in1_r_rdy, enc_in_vld}), 64'(4'b1000));
        end
        hold0 = 1'b0;
        wait_quiet("bp_done", 200);

        // Randomised traffic on both requesters with stalls everywhere.
        rnd_en = 1'b1;
        for (int it = 0; it < 16; it++) begin
            if ($urandom_range(1) == 1) send(0, int'($urandom_range(1, 8)), 16'($urandom));
            if ($urandom_range(1) == 1) send(1, int'($urandom_range(1, 8)), 16'($urandom));
            repeat ($urandom_range(0, 12)) tick();
        end
        wait_quiet("rand_done", 6000);
        rnd_en = 1'b0;

        // Reset in GRANT after two symbols: frame dropped, priority back to PRIO_INIT.
        send(0, 6, 16'b001101);
        k = 0;
        while (inq0.size() > 4 && k < 50) begin tick(); k++; end
        chk("mid_two_taken", 64'(inq0.size()), 64'(4));
        chk("mid_in_grant", 64'({busy, owner}), 64'(2'b10));
        do_reset();
        chk("mid_frames_zero", 64'({frames0, frames1}), 64'(0));
        send(0, 1, 16'b1);
        send(1, 1, 16'b0);
        tick(); tick();
        chk("post_reset_grant", 64'(owner), 64'(0));
        wait_quiet("post_reset_done", 200);
        chk("post_reset_frames", 64'({frames0, frames1}), 64'({8'd1, 8'd1}));

        // 256 single-symbol frames on in1: counter wraps back to 0.
        do_reset();
        for (int f = 0; f < 255; f++) send(1, 1, 16'($urandom));
        wait_quiet("wrap_a_done", 4000);
        chk("wrap_255", 64'(frames1), 64'(255));
        chk("wrap_f0_a", 64'(frames0), 64'(0));
        send(1, 1, 16'($urandom));
        wait_quiet("wrap_b_done", 100);
        chk("wrap_0", 64'(frames1), 64'(0));
        chk("wrap_f0_b", 64'(frames0), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
